// File: rtl/hpdcache_pkg.sv
// Shared HPDcache types used by the core request adapter and its FIFO.
package hpdcache_pkg;

    localparam int unsigned HPDCACHE_TAG_WIDTH = 28;
    localparam int unsigned HPDCACHE_REQ_ADAPTER_DEFAULT_MAX_OUTSTANDING = 8;

    typedef struct packed {
        logic uncacheable;
        logic io;
    } hpdcache_pma_t;

    // A zero field means "not constrained by the configuration".
    typedef struct packed {
        int unsigned tag_width;
        int unsigned n_requesters;
    } hpdcache_cfg_t;

    typedef struct packed {
        logic [11:0] addr_offset;
        logic [31:0] wdata;
        logic [3:0]  op;
        logic [2:0]  sid;
        logic [3:0]  tid;
        logic        need_rsp;
    } hpdcache_default_req_t;

endpackage

// File: rtl/hpdcache_fifo_reg.sv
// Generic DEPTH x WIDTH register FIFO; pointers wrap at DEPTH-1 so any DEPTH >= 1 works.
module hpdcache_fifo_reg #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [OCC_W-1:0] occ_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full_o  = (occ_q == OCC_W'(DEPTH));
    assign empty_o = (occ_q == '0);
    assign rdata_o = mem_q[rptr_q];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            if (push_i) wptr_q <= ptr_inc(wptr_q);
            if (pop_i)  rptr_q <= ptr_inc(rptr_q);
            if (push_i && !pop_i)      occ_q <= occ_q + OCC_W'(1);
            else if (pop_i && !push_i) occ_q <= occ_q - OCC_W'(1);
        end
    end

    // NOTE: storage is not reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o))
        else $error("push into a full FIFO");
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o))
        else $error("pop from an empty FIFO");
`endif

endmodule

// File: rtl/hpdcache_core_req_adapter.sv
// Per-requester front-end: queues single-cycle requests, re-times tag/PMA to the cycle
// after the handshake and limits in-flight requests that expect a response.
module hpdcache_core_req_adapter
    import hpdcache_pkg::*;
#(
    parameter hpdcache_cfg_t hpdcacheCfg     = '0,
    parameter type           hpdcache_req_t  = hpdcache_default_req_t,
    parameter type           hpdcache_tag_t  = logic [HPDCACHE_TAG_WIDTH-1:0],
    parameter int unsigned   DEPTH           = 2,
    parameter int unsigned   MAX_OUTSTANDING = HPDCACHE_REQ_ADAPTER_DEFAULT_MAX_OUTSTANDING,
    localparam int unsigned  CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_req_valid_i,
    output logic            in_req_ready_o,
    input  hpdcache_req_t   in_req_i,
    input  hpdcache_tag_t   in_tag_i,
    input  hpdcache_pma_t   in_pma_i,
    output logic            out_req_valid_o,
    input  logic            out_req_ready_i,
    output hpdcache_req_t   out_req_o,
    output logic            out_abort_o,
    output hpdcache_tag_t   out_tag_o,
    output hpdcache_pma_t   out_pma_o,
    input  logic            rsp_valid_i,
    output logic [CNT_W-1:0] outstanding_o,
    output logic            busy_o
);
    if (DEPTH < 1 || MAX_OUTSTANDING < 1) begin : g_param_check
        $error("DEPTH and MAX_OUTSTANDING must both be at least 1");
    end
    if (hpdcacheCfg.tag_width != 0 && hpdcacheCfg.tag_width != $bits(hpdcache_tag_t)) begin : g_cfg_check
        $error("hpdcache_tag_t width disagrees with the cache configuration");
    end

    typedef struct packed {
        hpdcache_req_t req;
        hpdcache_tag_t tag;
        hpdcache_pma_t pma;
    } entry_t;

    entry_t           push_entry;
    entry_t           head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             credit_ok;
    logic             issue_rsp;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    hpdcache_tag_t    tag_q;
    hpdcache_pma_t    pma_q;

    assign push_entry = '{req: in_req_i, tag: in_tag_i, pma: in_pma_i};
    assign push       = in_req_valid_i & ~full;
    assign pop        = out_req_valid_o & out_req_ready_i;

    hpdcache_fifo_reg #(
        .DEPTH(DEPTH),
        .WIDTH($bits(entry_t))
    ) i_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (push),
        .wdata_i(push_entry),
        .full_o (full),
        .pop_i  (pop),
        .rdata_o(head),
        .empty_o(empty)
    );

    // Readiness is a function of state only, so a full FIFO never accepts a pop-through push.
    assign in_req_ready_o  = ~full;
    assign credit_ok       = ~head.req.need_rsp | (cnt_q < CNT_W'(MAX_OUTSTANDING));
    assign out_req_valid_o = ~empty & credit_ok;
    assign out_req_o       = head.req;
    assign issue_rsp       = pop & head.req.need_rsp;

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (issue_rsp && !rsp_valid_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (rsp_valid_i && !issue_rsp && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            tag_q <= '0;
            pma_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (pop) begin
                tag_q <= head.tag;
                pma_q <= head.pma;
            end
        end
    end

    assign out_abort_o   = 1'b0;
    assign out_tag_o     = tag_q;
    assign out_pma_o     = pma_q;
    assign outstanding_o = cnt_q;
    assign busy_o        = ~empty | (cnt_q != '0);

`ifndef SYNTHESIS
    // The counter cannot rise without a pop, so a presented request stays presented.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_req_valid_o && !out_req_ready_i |=> out_req_valid_o && $stable(out_req_o))
        else $error("out_req_o changed while waiting for the arbiter");
    assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= CNT_W'(MAX_OUTSTANDING))
        else $error("outstanding counter above MAX_OUTSTANDING");
    assert property (@(posedge clk_i) disable iff (!rst_ni) rsp_valid_i |-> cnt_q != '0)
        else $warning("response received with no request outstanding");
`endif

endmodule

// File: tb/tb_hpdcache_core_req_adapter.sv
// Self-checking bench for hpdcache_core_req_adapter: directed vector table, corner sequences
// and randomized traffic compared against a queue-based reference model.
module tb_hpdcache_core_req_adapter;
    import hpdcache_pkg::*;

    localparam int unsigned DEPTH   = 3;
    localparam int unsigned MAX_OUT = 3;
    localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1);

    typedef hpdcache_default_req_t req_t;
    typedef logic [HPDCACHE_TAG_WIDTH-1:0] tag_t;

    localparam hpdcache_cfg_t CFG   = '{tag_width: HPDCACHE_TAG_WIDTH, n_requesters: 1};
    localparam hpdcache_pma_t PMA_A = '{uncacheable: 1'b0, io: 1'b1};

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             in_req_valid_i;
    logic             in_req_ready_o;
    req_t             in_req_i;
    tag_t             in_tag_i;
    hpdcache_pma_t    in_pma_i;
    logic             out_req_valid_o;
    logic             out_req_ready_i;
    req_t             out_req_o;
    logic             out_abort_o;
    tag_t             out_tag_o;
    hpdcache_pma_t    out_pma_o;
    logic             rsp_valid_i;
    logic [CNT_W-1:0] outstanding_o;
    logic             busy_o;

    hpdcache_core_req_adapter #(
        .hpdcacheCfg    (CFG),
        .hpdcache_req_t (req_t),
        .hpdcache_tag_t (tag_t),
        .DEPTH          (DEPTH),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .in_req_valid_i (in_req_valid_i),
        .in_req_ready_o (in_req_ready_o),
        .in_req_i       (in_req_i),
        .in_tag_i       (in_tag_i),
        .in_pma_i       (in_pma_i),
        .out_req_valid_o(out_req_valid_o),
        .out_req_ready_i(out_req_ready_i),
        .out_req_o      (out_req_o),
        .out_abort_o    (out_abort_o),
        .out_tag_o      (out_tag_o),
        .out_pma_o      (out_pma_o),
        .rsp_valid_i    (rsp_valid_i),
        .outstanding_o  (outstanding_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the FIFO is a queue, the credit count a plain integer.
    typedef struct packed {
        req_t          req;
        tag_t          tag;
        hpdcache_pma_t pma;
    } ent_t;

    ent_t          mq[$];
    int            m_out = 0;
    tag_t          m_tag = '0;
    hpdcache_pma_t m_pma = '0;

    function automatic bit model_valid();
        if (mq.size() == 0) return 1'b0;
        return !mq[0].req.need_rsp || (m_out < int'(MAX_OUT));
    endfunction

    task automatic check_model();
        bit mv;
        mv = model_valid();
        check("in_req_ready", 64'(in_req_ready_o), 64'(mq.size() < int'(DEPTH)));
        check("out_req_valid", 64'(out_req_valid_o), 64'(mv));
        if (mv) check("out_req", 64'(out_req_o), 64'(mq[0].req));
        check("outstanding", 64'(outstanding_o), 64'(m_out));
        check("busy", 64'(busy_o), 64'(mq.size() != 0 || m_out != 0));
        check("out_tag", 64'(out_tag_o), 64'(m_tag));
        check("out_pma", 64'(out_pma_o), 64'(m_pma));
        check("out_abort", 64'(out_abort_o), 64'(0));
    endtask

    task automatic apply(input logic iv, input req_t r, input tag_t t, input hpdcache_pma_t p,
                         input logic ordy, input logic rsp);
        @(negedge clk_i);
        in_req_valid_i  = iv;
        in_req_i        = r;
        in_tag_i        = t;
        in_pma_i        = p;
        out_req_ready_i = ordy;
        rsp_valid_i     = rsp;
        #1;
        check_model();
    endtask

    task automatic advance();
        bit   mv;
        bit   mr;
        bit   inc;
        ent_t e;
        mv = model_valid();
        mr = mq.size() < int'(DEPTH);
        @(posedge clk_i);
        inc = 1'b0;
        if (mv && out_req_ready_i) begin
            e     = mq.pop_front();
            m_tag = e.tag;
            m_pma = e.pma;
            inc   = e.req.need_rsp;
        end
        if (inc && !rsp_valid_i) m_out++;
        else if (!inc && rsp_valid_i && m_out > 0) m_out--;
        if (in_req_valid_i && mr) begin
            e.req = in_req_i;
            e.tag = in_tag_i;
            e.pma = in_pma_i;
            mq.push_back(e);
        end
    endtask

    function automatic req_t mk_req(input logic nr, input logic [11:0] off);
        req_t r;
        r             = '0;
        r.addr_offset = off;
        r.wdata       = {20'h5a5a5, off};
        r.op          = 4'h1;
        r.need_rsp    = nr;
        return r;
    endfunction

    typedef struct {
        logic iv;
        logic nr;
        tag_t tag;
        logic ordy;
        logic rsp;
        logic e_ready;
        logic e_valid;
        int   e_out;
        tag_t e_tag;
    } vec_t;

    function automatic vec_t v(input int iv, input int nr, input int tag, input int ordy, input int rsp,
                               input int er, input int ev, input int eo, input int et);
        vec_t x;
        x.iv = iv[0]; x.nr = nr[0]; x.tag = tag_t'(tag); x.ordy = ordy[0]; x.rsp = rsp[0];
        x.e_ready = er[0]; x.e_valid = ev[0]; x.e_out = eo; x.e_tag = tag_t'(et);
        return x;
    endfunction

    vec_t vecs[22];

    initial begin
        req_t r;
        in_req_valid_i  = 1'b0;
        in_req_i        = '0;
        in_tag_i        = '0;
        in_pma_i        = '0;
        out_req_ready_i = 1'b0;
        rsp_valid_i     = 1'b0;

        // Columns: valid, need_rsp, tag, out_ready, rsp | expected ready, valid, outstanding, out_tag
        vecs[0]  = v(1, 1, 'h1234, 1, 0,  1, 0, 0, 'h0);
        vecs[1]  = v(0, 0, 'h0,    1, 0,  1, 1, 0, 'h0);
        vecs[2]  = v(0, 0, 'h0,    1, 1,  1, 0, 1, 'h1234);
        vecs[3]  = v(0, 0, 'h0,    1, 0,  1, 0, 0, 'h1234);
        vecs[4]  = v(1, 1, 'hA1,   1, 0,  1, 0, 0, 'h1234);
        vecs[5]  = v(1, 1, 'hA2,   1, 0,  1, 1, 0, 'h1234);
        vecs[6]  = v(1, 1, 'hA3,   1, 0,  1, 1, 1, 'hA1);
        vecs[7]  = v(1, 1, 'hA4,   1, 0,  1, 1, 2, 'hA2);
        vecs[8]  = v(0, 0, 'h0,    1, 0,  1, 0, 3, 'hA3);
        vecs[9]  = v(0, 0, 'h0,    1, 1,  1, 0, 3, 'hA3);
        vecs[10] = v(0, 0, 'h0,    1, 0,  1, 1, 2, 'hA3);
        vecs[11] = v(0, 0, 'h0,    1, 0,  1, 0, 3, 'hA4);
        vecs[12] = v(1, 0, 'hB1,   1, 0,  1, 0, 3, 'hA4);
        vecs[13] = v(0, 0, 'h0,    1, 0,  1, 1, 3, 'hA4);
        vecs[14] = v(0, 0, 'h0,    1, 0,  1, 0, 3, 'hB1);
        vecs[15] = v(0, 0, 'h0,    1, 1,  1, 0, 3, 'hB1);
        vecs[16] = v(0, 0, 'h0,    1, 1,  1, 0, 2, 'hB1);
        vecs[17] = v(1, 1, 'hC1,   1, 0,  1, 0, 1, 'hB1);
        vecs[18] = v(0, 0, 'h0,    1, 1,  1, 1, 1, 'hB1);
        vecs[19] = v(0, 0, 'h0,    1, 0,  1, 0, 1, 'hC1);
        vecs[20] = v(0, 0, 'h0,    1, 1,  1, 0, 1, 'hC1);
        vecs[21] = v(0, 0, 'h0,    1, 0,  1, 0, 0, 'hC1);

        #3;
        check("reset in_req_ready", 64'(in_req_ready_o), 64'(1));
        check("reset out_req_valid", 64'(out_req_valid_o), 64'(0));
        check("reset outstanding", 64'(outstanding_o), 64'(0));
        check("reset busy", 64'(busy_o), 64'(0));
        check("reset out_tag", 64'(out_tag_o), 64'(0));
        #4 rst_ni = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].iv, mk_req(vecs[i].nr, 12'(i)), vecs[i].tag, PMA_A, vecs[i].ordy, vecs[i].rsp);
            check($sformatf("vec%0d ready", i), 64'(in_req_ready_o), 64'(vecs[i].e_ready));
            check($sformatf("vec%0d valid", i), 64'(out_req_valid_o), 64'(vecs[i].e_valid));
            check($sformatf("vec%0d outstanding", i), 64'(outstanding_o), 64'(vecs[i].e_out));
            check($sformatf("vec%0d out_tag", i), 64'(out_tag_o), 64'(vecs[i].e_tag));
            advance();
        end

        // Response with nothing outstanding: the counter must hold at zero.
        apply(1'b0, '0, '0, '0, 1'b0, 1'b1);
        advance();
        apply(1'b0, '0, '0, '0, 1'b0, 1'b0);
        check("underflow hold", 64'(outstanding_o), 64'(0));
        advance();

        // Stalled arbiter: FIFO fills, fourth push is refused, head stays put, then drains in order.
        for (int k = 0; k < 5; k++) begin
            apply(1'b1, mk_req(1'b0, 12'(k)), tag_t'('hF0 + k), PMA_A, 1'b0, 1'b0);
            check($sformatf("full ready k%0d", k), 64'(in_req_ready_o), 64'(k < int'(DEPTH)));
            if (k > 0) check($sformatf("stall head k%0d", k), 64'(out_req_o), 64'(mk_req(1'b0, 12'h0)));
            advance();
        end
        for (int k = 0; k < 4; k++) begin
            apply(1'b0, '0, '0, '0, 1'b1, 1'b0);
            if (k > 0) check($sformatf("drain tag k%0d", k), 64'(out_tag_o), 64'('hF0 + k - 1));
            advance();
        end

        // Reset in the middle of traffic: credit exhausted with two requests queued.
        for (int k = 0; k < 5; k++) begin
            apply(1'b1, mk_req(1'b1, 12'(k)), tag_t'('hE0 + k), PMA_A, 1'b1, 1'b0);
            advance();
        end
        apply(1'b0, '0, '0, '0, 1'b0, 1'b0);
        check("pre-reset outstanding", 64'(outstanding_o), 64'(MAX_OUT));
        check("pre-reset busy", 64'(busy_o), 64'(1));
        advance();
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("mid reset in_req_ready", 64'(in_req_ready_o), 64'(1));
        check("mid reset out_req_valid", 64'(out_req_valid_o), 64'(0));
        check("mid reset outstanding", 64'(outstanding_o), 64'(0));
        check("mid reset busy", 64'(busy_o), 64'(0));
        mq.delete();
        m_out = 0;
        m_tag = '0;
        m_pma = '0;
        check_model();
        #2 rst_ni = 1'b1;

        for (int n = 0; n < 1500; n++) begin
            logic iv;
            logic ordy;
            logic rsp;
            iv       = ($urandom_range(0, 9) < 7);
            ordy     = ($urandom_range(0, 9) < 6);
            rsp      = (m_out > 0) && ($urandom_range(0, 9) < 3);
            r        = mk_req(1'($urandom_range(0, 1)), 12'($urandom));
            r.wdata  = $urandom;
            r.tid    = 4'($urandom);
            apply(iv, r, tag_t'($urandom), hpdcache_pma_t'($urandom_range(0, 3)), ordy, rsp);
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
